// File: rtl/k051960_strip_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : k051960_strip_sequencer_if
// Purpose  : Bundles the two buses of the strip sequencer.
//            Entry side:  sprite list entries offered with ENT_VALID and
//                         consumed with ENT_READY.
//            Strip side:  ROM row address, strip latch (LACH/HP/OC/OHF),
//                         pixel advance (CARY) and end of line (HEND).
// Modports : master - the strip sequencer (takes entries, drives strips)
//            slave  - the environment (supplies entries, sinks strips)
// Revision : 1.0 - initial release
// ============================================================================
interface k051960_strip_sequencer_if #(
  parameter int ADDR_W = 18
);
  // Entry list side
  logic              ENT_VALID;
  logic              ENT_READY;
  logic [8:0]        ENT_X;
  logic [7:0]        ENT_COLOR;
  logic              ENT_FLIPX;
  logic [1:0]        ENT_WIDTH;
  logic [14:0]       ENT_CODE;
  logic [7:0]        ENT_SCALE;
  logic              ENT_LAST;

  // Strip side
  logic [ADDR_W-1:0] ROM_ADDR;
  logic              ROM_REQ;
  logic              LACH;
  logic [8:0]        HP;
  logic [7:0]        OC;
  logic              OHF;
  logic              CARY;
  logic              HEND;

  modport master (
    input  ENT_VALID, ENT_X, ENT_COLOR, ENT_FLIPX, ENT_WIDTH, ENT_CODE,
           ENT_SCALE, ENT_LAST,
    output ENT_READY, ROM_ADDR, ROM_REQ, LACH, HP, OC, OHF, CARY, HEND
  );

  modport slave (
    output ENT_VALID, ENT_X, ENT_COLOR, ENT_FLIPX, ENT_WIDTH, ENT_CODE,
           ENT_SCALE, ENT_LAST,
    input  ENT_READY, ROM_ADDR, ROM_REQ, LACH, HP, OC, OHF, CARY, HEND
  );
endinterface
`default_nettype wire

// File: rtl/k051960_strip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : k051960_strip_sequencer
// Purpose  : Walks the per-line list of visible sprite entries and emits
//            8-pixel strips to the sprite data processor: ROM row address,
//            strip latch, per-tick pixel advance, then end of line.
// Ports    : clk_24M    - master clock
//            nRES       - asynchronous active-low reset
//            EN12       - 12 MHz phase enable (a "tick" is an edge with EN12=1)
//            LINE_START - one-clk_24M pulse at line start
//            LIST_EMPTY - sampled with LINE_START, no entries this line
//            bus        - entry handshake and strip outputs (master view)
// Revision : 1.0 - initial release
// ============================================================================
module k051960_strip_sequencer #(
  parameter int LINE_CYC = 768,
  parameter int ADDR_W   = 18
) (
  input  wire clk_24M,
  input  wire nRES,
  output wire EN12,
  input  wire LINE_START,
  input  wire LIST_EMPTY,
  k051960_strip_sequencer_if.master bus
);

  localparam logic [9:0] c_BUDGET_LAST  = 10'(LINE_CYC - 1);
  localparam logic [9:0] c_BUDGET_FORCE = 10'(LINE_CYC - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_STRIP = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_en12;
  logic              r_ls_pend;
  logic              r_empty_pend;
  logic [9:0]        r_budget;
  logic [1:0]        r_phase;
  logic [2:0]        r_k;
  logic [2:0]        r_wm1;
  logic [7:0]        r_acc;
  logic [8:0]        r_xpos;
  logic [7:0]        r_scale;
  logic [14:0]       r_code;
  logic [7:0]        r_color;
  logic              r_flip;
  logic              r_last;

  logic              r_ent_ready;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_rom_req;
  logic              r_lach;
  logic [8:0]        r_hp;
  logic [7:0]        r_oc;
  logic              r_ohf;
  logic              r_cary;
  logic              r_hend;

  // A LINE_START seen on the off-phase edge is held until the next tick so
  // that every output still changes only on ticks.
  wire        w_ls         = LINE_START | r_ls_pend;
  wire        w_empty      = LINE_START ? LIST_EMPTY : r_empty_pend;
  wire        w_budget_end = (r_budget == c_BUDGET_FORCE);
  // Scale 0 stands for 256 (1:1); the 9th sum bit is the pixel carry.
  wire  [8:0] w_step       = (r_scale == 8'd0) ? 9'd256 : {1'b0, r_scale};
  wire  [8:0] w_sum        = {1'b0, r_acc} + w_step;
  wire        w_carry      = w_sum[8];
  // Flipped entries fetch their strips right-to-left.
  wire  [2:0] w_strip      = r_flip ? (r_wm1 - r_k) : r_k;
  wire  [3:0] w_wm1_full   = (4'd1 << bus.ENT_WIDTH) - 4'd1;

  assign EN12          = r_en12;
  assign bus.ENT_READY = r_ent_ready;
  assign bus.ROM_ADDR  = r_rom_addr;
  assign bus.ROM_REQ   = r_rom_req;
  assign bus.LACH      = r_lach;
  assign bus.HP        = r_hp;
  assign bus.OC        = r_oc;
  assign bus.OHF       = r_ohf;
  assign bus.CARY      = r_cary;
  assign bus.HEND      = r_hend;

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      r_state      <= S_IDLE;
      r_en12       <= 1'b0;
      r_ls_pend    <= 1'b0;
      r_empty_pend <= 1'b0;
      r_budget     <= 10'd0;
      r_phase      <= 2'd0;
      r_k          <= 3'd0;
      r_wm1        <= 3'd0;
      r_acc        <= 8'd0;
      r_xpos       <= 9'd0;
      r_scale      <= 8'd0;
      r_code       <= 15'd0;
      r_color      <= 8'd0;
      r_flip       <= 1'b0;
      r_last       <= 1'b0;
      r_ent_ready  <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_req    <= 1'b0;
      r_lach       <= 1'b0;
      r_hp         <= 9'd0;
      r_oc         <= 8'd0;
      r_ohf        <= 1'b0;
      r_cary       <= 1'b0;
      r_hend       <= 1'b0;
    end else begin
      r_en12 <= ~r_en12;
      if (!r_en12) begin
        if (LINE_START) begin
          r_ls_pend    <= 1'b1;
          r_empty_pend <= LIST_EMPTY;
        end
      end else begin
        r_ls_pend   <= 1'b0;
        r_ent_ready <= 1'b0;
        r_lach      <= 1'b0;
        r_rom_req   <= 1'b0;
        if (r_budget != c_BUDGET_LAST) begin
          r_budget <= r_budget + 10'd1;
        end

        if (w_ls) begin
          // Abort whatever is in flight; a coincident entry is left unconsumed.
          r_budget <= 10'd0;
          r_cary   <= 1'b0;
          r_hend   <= 1'b0;
          r_state  <= w_empty ? S_DONE : S_FETCH;
        end else if ((r_state == S_FETCH || r_state == S_STRIP) && w_budget_end) begin
          r_state <= S_DONE;
          r_cary  <= 1'b0;
          r_hend  <= 1'b1;
        end else begin
          case (r_state)
            S_IDLE: begin
              r_cary <= 1'b0;
            end
            S_FETCH: begin
              r_cary <= 1'b0;
              if (bus.ENT_VALID) begin
                r_ent_ready <= 1'b1;
                r_xpos      <= bus.ENT_X;
                r_color     <= bus.ENT_COLOR;
                r_flip      <= bus.ENT_FLIPX;
                r_wm1       <= w_wm1_full[2:0];
                r_code      <= bus.ENT_CODE;
                r_scale     <= bus.ENT_SCALE;
                r_last      <= bus.ENT_LAST;
                r_k         <= 3'd0;
                r_phase     <= 2'd0;
                r_acc       <= 8'd0;
                r_state     <= S_STRIP;
              end
            end
            S_STRIP: begin
              if (r_phase == 2'd0) begin
                r_rom_req  <= 1'b1;
                r_lach     <= 1'b1;
                r_rom_addr <= ADDR_W'({r_code, w_strip});
                r_hp       <= r_xpos;
                r_oc       <= r_color;
                r_ohf      <= r_flip;
              end
              r_acc   <= w_sum[7:0];
              r_cary  <= w_carry;
              // Each carry advances one pixel pair; wraps naturally at 512.
              r_xpos  <= r_xpos + {7'd0, w_carry, 1'b0};
              r_phase <= r_phase + 2'd1;
              if (r_phase == 2'd3) begin
                r_k <= r_k + 3'd1;
                if (r_k == r_wm1) begin
                  r_state <= r_last ? S_DONE : S_FETCH;
                end
              end
            end
            S_DONE: begin
              r_cary <= 1'b0;
              r_hend <= 1'b1;
            end
            default: begin
              r_state <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_k051960_strip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_k051960_strip_sequencer
// Purpose  : Directed self-checking bench for k051960_strip_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k051960_strip_sequencer;

  logic clk_24M = 1'b0;
  logic nRES;
  logic LINE_START;
  logic LIST_EMPTY;
  wire  EN12;

  always #5 clk_24M = ~clk_24M;

  k051960_strip_sequencer_if #(.ADDR_W(18)) bus ();

  k051960_strip_sequencer #(.LINE_CYC(768), .ADDR_W(18)) dut (
    .clk_24M    (clk_24M),
    .nRES       (nRES),
    .EN12       (EN12),
    .LINE_START (LINE_START),
    .LIST_EMPTY (LIST_EMPTY),
    .bus        (bus.master)
  );

  // Bench-side copy of the 12 MHz phase, used only to find tick edges.
  logic m_en12;
  always @(posedge clk_24M or negedge nRES) begin
    if (!nRES) m_en12 <= 1'b0;
    else       m_en12 <= ~m_en12;
  end

  int n_assert = 0;
  int n_fail   = 0;

  int          obs_lach;
  int          obs_cary;
  logic [31:0] obs_pat;
  logic [8:0]  obs_hp   [4];
  logic [17:0] obs_addr [4];
  logic        obs_ohf  [4];
  int          obs_lt   [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next tick edge.
  task automatic next_tick();
    logic was;
    was = 1'b0;
    while (!was) begin
      @(posedge clk_24M);
      was = m_en12;
    end
    #1;
  endtask

  // LINE_START pulse that spans exactly one tick edge; that tick is T0.
  task automatic line_start(input logic empty);
    next_tick();
    @(posedge clk_24M);
    #1;
    LINE_START = 1'b1;
    LIST_EMPTY = empty;
    next_tick();
    LINE_START = 1'b0;
    LIST_EMPTY = 1'b0;
  endtask

  task automatic set_entry(input logic [8:0] x, input logic [7:0] color, input logic flip,
                           input logic [1:0] width, input logic [14:0] code,
                           input logic [7:0] scale, input logic last);
    bus.ENT_X     = x;
    bus.ENT_COLOR = color;
    bus.ENT_FLIPX = flip;
    bus.ENT_WIDTH = width;
    bus.ENT_CODE  = code;
    bus.ENT_SCALE = scale;
    bus.ENT_LAST  = last;
  endtask

  task automatic observe(input int n);
    obs_lach = 0;
    obs_cary = 0;
    obs_pat  = 32'd0;
    for (int t = 0; t < n; t++) begin
      next_tick();
      obs_pat = {obs_pat[30:0], bus.CARY};
      if (bus.CARY) obs_cary++;
      if (bus.LACH) begin
        if (obs_lach < 4) begin
          obs_hp[obs_lach]   = bus.HP;
          obs_addr[obs_lach] = bus.ROM_ADDR;
          obs_ohf[obs_lach]  = bus.OHF;
          obs_lt[obs_lach]   = t;
        end
        obs_lach++;
      end
    end
  endtask

  initial begin
    nRES       = 1'b0;
    LINE_START = 1'b0;
    LIST_EMPTY = 1'b0;
    bus.ENT_VALID = 1'b0;
    set_entry(9'd0, 8'd0, 1'b0, 2'd0, 15'd0, 8'd0, 1'b0);

    // Reset state
    #1;
    chk("rst_en12",  32'(EN12),         32'd0);
    chk("rst_lach",  32'(bus.LACH),     32'd0);
    chk("rst_req",   32'(bus.ROM_REQ),  32'd0);
    chk("rst_addr",  32'(bus.ROM_ADDR), 32'd0);
    chk("rst_hp",    32'(bus.HP),       32'd0);
    chk("rst_oc",    32'(bus.OC),       32'd0);
    chk("rst_cary",  32'(bus.CARY),     32'd0);
    chk("rst_hend",  32'(bus.HEND),     32'd0);
    chk("rst_ready", 32'(bus.ENT_READY),32'd0);
    #23 nRES = 1'b1;
    repeat (4) next_tick();
    chk("idle_hend", 32'(bus.HEND), 32'd0);
    chk("idle_lach", 32'(bus.LACH), 32'd0);
    chk("idle_en12", 32'(EN12),     32'd0);

    // Two-strip entry at 1:1
    set_entry(9'h010, 8'h5A, 1'b0, 2'd1, 15'h0123, 8'd0, 1'b1);
    bus.ENT_VALID = 1'b1;
    line_start(1'b0);
    chk("t1_t0_ready", 32'(bus.ENT_READY), 32'd0);
    next_tick();
    chk("t1_ready", 32'(bus.ENT_READY), 32'd1);
    chk("t1_lach_early", 32'(bus.LACH), 32'd0);
    observe(8);
    chk("t1_lach_n", 32'(obs_lach), 32'd2);
    chk("t1_lach_gap", 32'(obs_lt[1] - obs_lt[0]), 32'd4);
    chk("t1_hp0", 32'(obs_hp[0]), 32'h010);
    chk("t1_hp1", 32'(obs_hp[1]), 32'h018);
    chk("t1_addr0", 32'(obs_addr[0]), 32'h0918);
    chk("t1_addr1", 32'(obs_addr[1]), 32'h0919);
    chk("t1_ohf", 32'(obs_ohf[0]), 32'd0);
    chk("t1_cary_n", 32'(obs_cary), 32'd8);
    chk("t1_oc", 32'(bus.OC), 32'h5A);
    chk("t1_hp_hold", 32'(bus.HP), 32'h018);
    chk("t1_hend_pre", 32'(bus.HEND), 32'd0);
    next_tick();
    chk("t1_hend", 32'(bus.HEND), 32'd1);
    chk("t1_cary_done", 32'(bus.CARY), 32'd0);

    // Same entry flipped
    set_entry(9'h010, 8'h5A, 1'b1, 2'd1, 15'h0123, 8'd0, 1'b1);
    line_start(1'b0);
    chk("fl_hend_drop", 32'(bus.HEND), 32'd0);
    next_tick();
    observe(8);
    chk("fl_addr0", 32'(obs_addr[0]), 32'h0919);
    chk("fl_addr1", 32'(obs_addr[1]), 32'h0918);
    chk("fl_ohf", 32'(obs_ohf[0]), 32'd1);
    chk("fl_hp0", 32'(obs_hp[0]), 32'h010);
    chk("fl_hp1", 32'(obs_hp[1]), 32'h018);
    next_tick();
    chk("fl_hend", 32'(bus.HEND), 32'd1);

    // Half scale with X wrap: CARY 0,1 pattern carries across strips
    set_entry(9'h1FE, 8'h33, 1'b0, 2'd1, 15'h0001, 8'd128, 1'b1);
    line_start(1'b0);
    next_tick();
    observe(8);
    chk("wr_pat", obs_pat & 32'hFF, 32'h55);
    chk("wr_hp0", 32'(obs_hp[0]), 32'h1FE);
    chk("wr_hp1", 32'(obs_hp[1]), 32'h002);
    chk("wr_addr0", 32'(obs_addr[0]), 32'h8);
    chk("wr_addr1", 32'(obs_addr[1]), 32'h9);

    // Single-strip last entry: DONE right after its 4 ticks
    set_entry(9'h040, 8'h11, 1'b0, 2'd0, 15'h7FFF, 8'd0, 1'b1);
    line_start(1'b0);
    next_tick();
    observe(4);
    chk("w0_lach_n", 32'(obs_lach), 32'd1);
    chk("w0_addr", 32'(obs_addr[0]), 32'h3FFF8);
    chk("w0_cary_n", 32'(obs_cary), 32'd4);
    chk("w0_hend_pre", 32'(bus.HEND), 32'd0);
    next_tick();
    chk("w0_hend", 32'(bus.HEND), 32'd1);

    // Empty list, LINE_START caught on the off-phase edge
    next_tick();
    LINE_START = 1'b1;
    LIST_EMPTY = 1'b1;
    @(posedge clk_24M);
    #1;
    LINE_START = 1'b0;
    LIST_EMPTY = 1'b0;
    next_tick();
    chk("em_hend_drop", 32'(bus.HEND), 32'd0);
    next_tick();
    chk("em_hend", 32'(bus.HEND), 32'd1);
    chk("em_ready", 32'(bus.ENT_READY), 32'd0);
    chk("em_lach", 32'(bus.LACH), 32'd0);

    // FETCH stall, then LINE_START coincident with ENT_VALID
    bus.ENT_VALID = 1'b0;
    set_entry(9'h100, 8'h22, 1'b0, 2'd0, 15'h0010, 8'd0, 1'b1);
    line_start(1'b0);
    repeat (3) next_tick();
    chk("st_ready", 32'(bus.ENT_READY), 32'd0);
    chk("st_lach", 32'(bus.LACH), 32'd0);
    chk("st_cary", 32'(bus.CARY), 32'd0);
    @(posedge clk_24M);
    #1;
    bus.ENT_VALID = 1'b1;
    LINE_START = 1'b1;
    next_tick();
    LINE_START = 1'b0;
    chk("co_ready", 32'(bus.ENT_READY), 32'd0);
    next_tick();
    chk("co_ready_next", 32'(bus.ENT_READY), 32'd1);
    observe(4);
    chk("co_hp", 32'(obs_hp[0]), 32'h100);
    next_tick();
    chk("co_hend", 32'(bus.HEND), 32'd1);

    // Budget exhaustion with an endless list of one-strip entries
    set_entry(9'h000, 8'h01, 1'b0, 2'd0, 15'h0002, 8'd0, 1'b0);
    line_start(1'b0);
    observe(766);
    chk("bu_hend_pre", 32'(bus.HEND), 32'd0);
    next_tick();
    chk("bu_hend", 32'(bus.HEND), 32'd1);
    chk("bu_cary", 32'(bus.CARY), 32'd0);
    chk("bu_lach_last", 32'(bus.LACH), 32'd0);
    chk("bu_lach_n", 32'(obs_lach), 32'd153);
    observe(6);
    chk("bu_after_cary", 32'(obs_cary), 32'd0);
    chk("bu_after_lach", 32'(obs_lach), 32'd0);
    chk("bu_after_hend", 32'(bus.HEND), 32'd1);

    // Reset in the middle of a strip
    set_entry(9'h010, 8'h5A, 1'b0, 2'd1, 15'h0123, 8'd0, 1'b1);
    line_start(1'b0);
    next_tick();
    next_tick();
    chk("mr_lach_pre", 32'(bus.LACH), 32'd1);
    #2 nRES = 1'b0;
    #1;
    chk("mr_lach", 32'(bus.LACH), 32'd0);
    chk("mr_req", 32'(bus.ROM_REQ), 32'd0);
    chk("mr_hp", 32'(bus.HP), 32'd0);
    chk("mr_addr", 32'(bus.ROM_ADDR), 32'd0);
    chk("mr_oc", 32'(bus.OC), 32'd0);
    chk("mr_cary", 32'(bus.CARY), 32'd0);
    chk("mr_en12", 32'(EN12), 32'd0);
    repeat (3) @(posedge clk_24M);
    #2 nRES = 1'b1;
    observe(6);
    chk("mr_idle_lach", 32'(obs_lach), 32'd0);
    chk("mr_idle_ready", 32'(bus.ENT_READY), 32'd0);
    chk("mr_idle_hend", 32'(bus.HEND), 32'd0);
    line_start(1'b0);
    next_tick();
    chk("mr_restart_ready", 32'(bus.ENT_READY), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
